// File: rtl/zap_fetch_fifo_if.sv
// zap_fetch_fifo_if: fetch-beat input and decode-head output bundle of the
// fetch FIFO. The slave modport is the FIFO itself; the master modport is
// the fetch/decode side that drives beats and consumes the head entry.
interface zap_fetch_fifo_if;
  // fetch -> FIFO
  logic        i_valid;
  logic [31:0] i_instruction;
  logic        i_instr_abort;
  logic [31:0] i_pc_ff;
  logic [31:0] i_pc_plus_8_ff;
  logic [1:0]  i_taken;
  // FIFO -> fetch
  logic        o_stall_to_fetch;
  // FIFO -> decode
  logic        o_valid;
  logic [31:0] o_instruction;
  logic        o_instr_abort;
  logic [31:0] o_pc_ff;
  logic [31:0] o_pc_plus_8_ff;
  logic [1:0]  o_taken_ff;

  modport slave (
    input  i_valid, i_instruction, i_instr_abort, i_pc_ff, i_pc_plus_8_ff, i_taken,
    output o_stall_to_fetch,
    output o_valid, o_instruction, o_instr_abort, o_pc_ff, o_pc_plus_8_ff, o_taken_ff
  );

  modport master (
    output i_valid, i_instruction, i_instr_abort, i_pc_ff, i_pc_plus_8_ff, i_taken,
    input  o_stall_to_fetch,
    input  o_valid, o_instruction, o_instr_abort, o_pc_ff, o_pc_plus_8_ff, o_taken_ff
  );
endinterface

// File: rtl/zap_fetch_fifo.sv
// zap_fetch_fifo: elastic buffer between fetch and decode. Beats are held in
// a DEPTH-entry FIFO behind a registered head entry, so fetch only stalls
// when storage is full. Clears/stalls follow the pipeline priority chain:
// writeback clear > data stall > ALU clear > decode clear.
// Optional feature macro: ZAP_FETCH_FIFO_ABORT_SLEEP_EN (stop accepting
// beats after an aborted instruction until the next clear).
module zap_fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_clear_from_writeback,
  input  logic                     i_data_stall,
  input  logic                     i_clear_from_alu,
  input  logic                     i_stall_downstream,
  input  logic                     i_clear_from_decode,
  zap_fetch_fifo_if.slave          io_fifo,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 99;
  // Reset head: PC+8 of the reset vector is 8, everything else zero.
  localparam logic [EW-1:0] RESET_ENTRY = {2'd0, 32'd8, 32'd0, 1'b0, 32'd0};

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_out_valid;
  logic [EW-1:0] r_out_entry;

  logic          w_clear;
  logic          w_freeze;
  logic          w_full;
  logic          w_empty;
  logic          w_sleep;
  logic          w_push;
  logic          w_advance;
  logic          w_pop;
  logic          w_bypass;
  logic          w_write;
  logic [EW-1:0] w_in_entry;

  // Entry layout {taken, pc+8, pc, abort, instr}, carried verbatim.
  assign w_in_entry = {io_fifo.i_taken, io_fifo.i_pc_plus_8_ff, io_fifo.i_pc_ff,
                       io_fifo.i_instr_abort, io_fifo.i_instruction};

  // A data stall masks the ALU/decode clears but not the writeback clear.
  assign w_clear  = i_clear_from_writeback |
                    (~i_data_stall & (i_clear_from_alu | i_clear_from_decode));
  assign w_freeze = ~i_clear_from_writeback & i_data_stall;

  // Same low bits with differing wrap bits means full; identical means empty.
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign io_fifo.o_stall_to_fetch = w_full;

  assign w_push    = io_fifo.i_valid & ~w_full & ~w_clear & ~w_freeze & ~w_sleep;
  assign w_advance = ~w_clear & ~w_freeze & (~i_stall_downstream | ~r_out_valid);
  assign w_pop     = w_advance & ~w_empty;
  // Empty storage and a free head: the beat skips storage entirely.
  assign w_bypass  = w_advance & w_empty & w_push;
  assign w_write   = w_push & ~w_bypass;

`ifdef ZAP_FETCH_FIFO_ABORT_SLEEP_EN
  logic r_sleep;
  // Sleep after accepting an aborted beat; any clear wakes the buffer.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                        r_sleep <= 1'b0;
    else if (w_clear)                      r_sleep <= 1'b0;
    else if (w_push & io_fifo.i_instr_abort) r_sleep <= 1'b1;
  end
  assign w_sleep = r_sleep;
`else
  assign w_sleep = 1'b0;
`endif

  // Storage write; contents need no reset since the pointers gate them.
  always_ff @(posedge i_clk) begin
    if (w_write) r_mem[r_wr_ptr[AW-1:0]] <= w_in_entry;
  end

  // Pointer update: a clear empties storage, otherwise count push/pop.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Head register: loads from storage first, else bypasses the input beat.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_out_valid <= 1'b0;
      r_out_entry <= RESET_ENTRY;
    end else if (w_clear) begin
      r_out_valid     <= 1'b0;
      r_out_entry[32] <= 1'b0;
    end else if (w_advance) begin
      if (w_pop) begin
        r_out_valid <= 1'b1;
        r_out_entry <= r_mem[r_rd_ptr[AW-1:0]];
      end else if (w_bypass) begin
        r_out_valid <= 1'b1;
        r_out_entry <= w_in_entry;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign io_fifo.o_valid        = r_out_valid;
  assign io_fifo.o_instruction  = r_out_entry[31:0];
  assign io_fifo.o_instr_abort  = r_out_entry[32];
  assign io_fifo.o_pc_ff        = r_out_entry[64:33];
  assign io_fifo.o_pc_plus_8_ff = r_out_entry[96:65];
  assign io_fifo.o_taken_ff     = r_out_entry[98:97];

endmodule

// File: tb/tb_zap_fetch_fifo.sv
// tb_zap_fetch_fifo: scoreboard bench for zap_fetch_fifo (DEPTH=4). Every
// accepted beat is queued; the decode head must always equal the queue front.
module tb_zap_fetch_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wb_clr = 1'b0, dstall = 1'b0, alu_clr = 1'b0, sdown = 1'b0, dec_clr = 1'b0;
  logic [2:0] cnt;

  zap_fetch_fifo_if ff ();

  zap_fetch_fifo #(.DEPTH(4)) dut (
    .i_clk                 (clk),
    .i_reset_n             (rst_n),
    .i_clear_from_writeback(wb_clr),
    .i_data_stall          (dstall),
    .i_clear_from_alu      (alu_clr),
    .i_stall_downstream    (sdown),
    .i_clear_from_decode   (dec_clr),
    .io_fifo               (ff.slave),
    .o_count               (cnt)
  );

  always #5 clk = ~clk;

`ifdef ZAP_FETCH_FIFO_ABORT_SLEEP_EN
  localparam bit SLEEP_EN = 1'b1;
`else
  localparam bit SLEEP_EN = 1'b0;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_popped = 0;
  int          n_accepted = 0;
  bit          last_acc;
  bit          m_sleep = 1'b0;
  logic [98:0] q[$];

  task automatic check(input string tag, input logic [98:0] got, input logic [98:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [98:0] head_obs();
    return {ff.o_taken_ff, ff.o_pc_plus_8_ff, ff.o_pc_ff, ff.o_instr_abort, ff.o_instruction};
  endfunction

  function automatic int exp_count();
    return (q.size() > 0) ? q.size() - 1 : 0;
  endfunction

  task automatic set_beat(input logic [31:0] instr, input logic [31:0] pc,
                          input logic abort, input logic [1:0] tk);
    ff.i_valid        = 1'b1;
    ff.i_instruction  = instr;
    ff.i_pc_ff        = pc;
    ff.i_pc_plus_8_ff = pc + 32'd8;
    ff.i_instr_abort  = abort;
    ff.i_taken        = tk;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, ff.o_valid, q.size() > 0);
    check({tag, ".count"}, cnt, exp_count());
    check({tag, ".stall"}, ff.o_stall_to_fetch, exp_count() == 4);
    if (q.size() > 0) check({tag, ".head"}, head_obs(), q[0]);
  endtask

  // One clock: predict accept/consume from the inputs, clock, update, compare.
  task automatic step(input string tag);
    bit          clr, cons, acc;
    logic [98:0] in_e;
    clr  = wb_clr | (!dstall & (alu_clr | dec_clr));
    cons = (q.size() > 0) && !sdown;
    acc  = ff.i_valid && (exp_count() != 4) && !clr && !dstall && !m_sleep;
    in_e = {ff.i_taken, ff.i_pc_plus_8_ff, ff.i_pc_ff, ff.i_instr_abort, ff.i_instruction};
    last_acc = acc;
    @(posedge clk);
    #1;
    if (clr) begin
      q.delete();
      m_sleep = 1'b0;
    end else if (!dstall) begin
      if (cons) begin
        $display("[%0t] %s: decode took pc=%h", $time, tag, q[0][64:33]);
        void'(q.pop_front());
        n_popped++;
      end
      if (acc) begin
        q.push_back(in_e);
        n_accepted++;
        if (SLEEP_EN && in_e[32]) m_sleep = 1'b1;
      end
    end
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    ff.i_valid = 1'b0;
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    int k, base_pop, base_acc;
    ff.i_valid = 1'b0; ff.i_instruction = '0; ff.i_instr_abort = 1'b0;
    ff.i_pc_ff = '0; ff.i_pc_plus_8_ff = '0; ff.i_taken = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", ff.o_valid, 1'b0);
    check("rst.pc8", ff.o_pc_plus_8_ff, 32'd8);
    check("rst.instr", ff.o_instruction, 32'd0);
    check("rst.count", cnt, 3'd0);
    check("rst.stall", ff.o_stall_to_fetch, 1'b0);
    rst_n = 1'b1;

    // Single beat, one-cycle latency through the bypass
    set_beat(32'hE1A00000, 32'h100, 1'b0, 2'd2);
    step("single");
    check("single.pc8", ff.o_pc_plus_8_ff, 32'h108);
    check("single.taken", ff.o_taken_ff, 2'd2);
    idle(2, "single_drain");

    // Fill under downstream stall; 6th beat must be refused
    sdown = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_beat(32'hA000_0000 + i, 32'h200 + 4 * i, 1'b0, i[1:0]);
      step("fill");
    end
    check("fill.count4", cnt, 3'd4);
    check("fill.stall", ff.o_stall_to_fetch, 1'b1);
    check("fill.sixth_refused", last_acc, 1'b0);
    sdown = 1'b0;
    idle(6, "fill_drain");

    // Wrap: 20 beats, fetch holds a refused beat, downstream stall alternates
    base_pop = n_popped; base_acc = n_accepted; k = 0;
    for (int c = 0; c < 200 && k < 20; c++) begin
      set_beat(32'hB000_0000 + k, 32'h1000 + 4 * k, 1'b0, k[1:0]);
      sdown = c[0] | c[2];
      step("wrap");
      if (last_acc) k++;
    end
    sdown = 1'b0;
    idle(8, "wrap_drain");
    check("wrap.accepted", n_accepted - base_acc, 20);
    check("wrap.emitted", n_popped - base_pop, 20);

    // Clear priority: data stall masks the ALU clear; writeback clear wins
    sdown = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_beat(32'hC000_0000 + i, 32'h300 + 4 * i, 1'b1, 2'd1);
      step("prio_fill");
    end
    check("prio.count3", cnt, 3'd3);
    set_beat(32'hC0DE_0000, 32'h3F0, 1'b0, 2'd0);
    dstall = 1'b1; alu_clr = 1'b1;
    step("prio_dstall_alu");
    dstall = 1'b0; alu_clr = 1'b0; wb_clr = 1'b1;
    step("prio_wb");
    wb_clr = 1'b0;
    check("prio.abort_cleared", ff.o_instr_abort, 1'b0);
    sdown = 1'b0;
    idle(2, "prio_idle");

    // Abort beat followed by two normal beats
    base_acc = n_accepted;
    set_beat(32'hD000_0000, 32'h400, 1'b1, 2'd3);
    step("abort");
    check("abort.flag", ff.o_instr_abort, 1'b1);
    set_beat(32'hD000_0001, 32'h404, 1'b0, 2'd0);
    step("abort_next1");
    set_beat(32'hD000_0002, 32'h408, 1'b0, 2'd0);
    step("abort_next2");
    check("abort.accepted", n_accepted - base_acc, SLEEP_EN ? 1 : 3);
    idle(3, "abort_drain");
    dec_clr = 1'b1;
    step("abort_clear");
    dec_clr = 1'b0;
    set_beat(32'hD000_0003, 32'h40C, 1'b0, 2'd1);
    step("abort_wake");
    check("abort.wake_valid", ff.o_valid, 1'b1);
    idle(2, "abort_wake_drain");

    // Asynchronous reset in the middle of a cycle with two entries stored
    sdown = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_beat(32'hE000_0000 + i, 32'h500 + 4 * i, 1'b0, 2'd2);
      step("areset_fill");
    end
    check("areset.count2", cnt, 3'd2);
    ff.i_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("areset.valid", ff.o_valid, 1'b0);
    check("areset.pc8", ff.o_pc_plus_8_ff, 32'd8);
    check("areset.count", cnt, 3'd0);
    check("areset.stall", ff.o_stall_to_fetch, 1'b0);
    q.delete();
    m_sleep = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sdown = 1'b0;
    set_beat(32'hF000_0000, 32'h600, 1'b0, 2'd0);
    step("after_reset");
    idle(2, "after_reset_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/zap_fetch_fifo.md
# zap_fetch_fifo

Elastic instruction buffer between the fetch stage and decode. Captures each valid fetch beat (instruction, abort flag, PC, PC+8, 2-bit branch-predictor state) into a DEPTH-entry FIFO and presents a registered head entry to decode. Fetch then sees only a full-based stall instead of every decode/issue/shifter stall. Obeys the pipeline clear/stall priority chain.

## Interface
- DEPTH, 4, number of FIFO entries, power of two, ≥2.
- i_clk  in  1  core clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_clear_from_writeback  in  1  flush, highest priority.
- i_data_stall  in  1  freeze.
- i_clear_from_alu  in  1  flush.
- i_stall_downstream  in  1  OR of shifter/issue/decode stalls; freezes output register.
- i_clear_from_decode  in  1  flush, lowest priority.
- i_valid  in  1  fetch beat valid.
- i_instruction  in  32  fetched instruction.
- i_instr_abort  in  1  instruction abort flag.
- i_pc_ff  in  32  PC of beat.
- i_pc_plus_8_ff  in  32  PC+8 (or +4 in T state) of beat.
- i_taken  in  2  predictor state of beat.
- o_stall_to_fetch  out  1  FIFO full; fetch must hold.
- o_valid  out  1  head entry valid to decode.
- o_instruction  out  32  head instruction.
- o_instr_abort  out  1  head abort flag.
- o_pc_ff  out  32  head PC.
- o_pc_plus_8_ff  out  32  head PC+8.
- o_taken_ff  out  2  head predictor state.
- o_count  out  $clog2(DEPTH)+1  entries held in FIFO storage, excluding output register.

## Operation
- Reset (async, i_reset_n low): all pointers/count 0, sleep 0, o_valid 0, o_instr_abort 0, o_instruction 0, o_pc_ff 0, o_pc_plus_8_ff 32'd8, o_taken_ff 2'd0, o_stall_to_fetch 0.
- Priority per cycle: writeback clear > data stall > ALU clear > decode clear > normal. Any clear empties storage, sets o_valid 0 and o_instr_abort 0, clears sleep, drops the same-cycle input. Data stall freezes all state, with no push and no pop.
- o_stall_to_fetch = (o_count == DEPTH). It is combinational from count only.
- push = i_valid & !o_stall_to_fetch & no clear & !i_data_stall & !sleep.
- Output register advance: allowed when !i_stall_downstream or o_valid==0.
  - On advance, load the head entry if storage is non-empty (pop).
  - Else, if push, bypass the input directly into the output register, with no storage write.
  - Else, set o_valid 0.
- Push with no bypass writes storage at wr_ptr.
- Pointers are $clog2(DEPTH)+1 bits. Full/empty are decided by MSB comparison. Wrap is natural modulo 2·DEPTH.
- Simultaneous push+pop when not full: count unchanged, order preserved.
- Push is rejected at full even if a pop occurs in the same cycle.
- Entry width is 99 bits {taken, pc+8, pc, abort, instr}, stored verbatim with no arithmetic.

## Timing
- Latency with empty FIFO and free output register: a beat accepted at edge N is visible on o_* after edge N (one cycle).
- Latency when buffered: one cycle per older entry ahead of it.
- Throughput: one beat per cycle in steady state.
- A clear asserted in cycle N leaves o_valid=0 and o_count=0 after edge N.
- Reset may assert mid-operation at any phase. Outputs take reset values immediately, without waiting for a clock edge.

## Configuration
- ZAP_FETCH_FIFO_ABORT_SLEEP_EN defined: accepting a beat with i_instr_abort=1 sets sleep. While sleep=1 all further pushes are dropped, and o_stall_to_fetch is unaffected. Any clear wakes the block. Already-buffered entries still drain.
- Undefined: sleep is held at 0 and beats after an abort are buffered normally.

## Test plan
- Reset then single beat: i_valid=1, instr=32'hE1A00000, pc=0x100, pc+8=0x108, taken=2 -> next cycle o_valid=1 with identical fields; o_count=0.
- Fill: hold i_stall_downstream=1, push 5 beats with DEPTH=4 -> o_count=4, o_stall_to_fetch=1, and the 6th beat is not accepted. Release the stall -> beats emerge in order, one per cycle.
- Wrap: 20 beats with alternating downstream stall -> output PC sequence strictly matches the input sequence with no loss or duplication.
- Clear priority: with 3 entries buffered, assert i_data_stall and i_clear_from_alu together -> state unchanged. Assert i_clear_from_writeback -> o_valid=0 and o_count=0 next cycle.
- Abort with ZAP_FETCH_FIFO_ABORT_SLEEP_EN: push an abort beat, then 2 normal beats -> only the abort beat emerges, with o_instr_abort=1. After i_clear_from_decode, the next beat is accepted.
- Async reset mid-fill: drop i_reset_n between clock edges with o_count=2 -> o_valid=0 and o_pc_plus_8_ff=8 immediately.
